// File: rtl/hilo_muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit_if
//
// Bundle between the instruction decoder and the HI/LO multiply/divide unit.
//
//   funct      decoder -> unit   R-type function field of the decode instruction
//   HI_write   decoder -> unit   HI write strobe, only 2'b11 counts
//   LO_write   decoder -> unit   LO write strobe, only 2'b11 counts
//   hilo_read  decoder -> unit   decode instruction is MFHI/MFLO
//   rs_data    decoder -> unit   operand A / MTHI-MTLO source
//   rt_data    decoder -> unit   operand B
//   hi, lo     unit -> decoder   architectural HI / LO registers
//   busy       unit -> decoder   engine not idle
//   stall      unit -> decoder   freeze fetch/decode
// ---------------------------------------------------------------------------
interface hilo_muldiv_unit_if;
    logic [5:0]  funct;
    logic [1:0]  HI_write;
    logic [1:0]  LO_write;
    logic        hilo_read;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    modport master (
        output funct, HI_write, LO_write, hilo_read, rs_data, rt_data,
        input  hi, lo, busy, stall
    );

    modport slave (
        input  funct, HI_write, LO_write, hilo_read, rs_data, rt_data,
        output hi, lo, busy, stall
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
//
// Multi-cycle multiply/divide engine owning the HI and LO registers.
// MTHI/MTLO write in one edge; MULT/MULTU/DIV/DIVU run one shift-add or
// restoring shift-subtract step per cycle on unsigned magnitudes, then a
// final cycle applies the sign fixup and writes HI/LO.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    hilo_muldiv_unit_if.slave (decoder strobes/operands in,
//          hi/lo/busy/stall out)
//
// Parameters:
//   ITER_CYCLES  iterative steps per MULT/DIV (32 for a 32-bit datapath)
//
// Build option:
//   HILO_FAST_MULT_EN  when defined, MULT/MULTU complete on the issue edge
//                      through a combinational 32x32 multiplier; divides
//                      stay iterative.
// ---------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int ITER_CYCLES = 32
) (
    input  logic               clk,
    input  logic               reset,
    hilo_muldiv_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(ITER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES - 1);

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } state_e;

    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [31:0]      hi_q,     hi_d;
    logic [31:0]      lo_q,     lo_d;
    logic [31:0]      a_q,      a_d;      // multiplicand / divisor magnitude
    logic [31:0]      b_q,      b_d;      // multiplier -> product low / dividend -> quotient
    logic [31:0]      p_q,      p_d;      // product high / partial remainder
    logic             is_div_q, is_div_d;
    logic             neg_q,    neg_d;    // operand signs differ
    logic             rs_neg_q, rs_neg_d; // dividend sign, for the remainder
    logic             busy_q,   busy_d;

    logic        strobe;
    logic        issue;
    logic        signed_op;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] prod_fixed;
    logic        start;
`ifdef HILO_FAST_MULT_EN
    logic [63:0] fast_prod;
`endif

    // NOTE: every signal driven here gets a default at the top of the block;
    // a path that leaves one unassigned would otherwise infer a latch.
    always_comb begin
        strobe    = (bus.HI_write == 2'b11) || (bus.LO_write == 2'b11);
        issue     = strobe && (state_q == ST_IDLE);
        signed_op = (bus.funct == F_MULT) || (bus.funct == F_DIV);
        rs_neg    = signed_op && bus.rs_data[31];
        rt_neg    = signed_op && bus.rt_data[31];
        // 0x80000000 negates to itself, which read unsigned is 2^31.
        rs_mag    = rs_neg ? -bus.rs_data : bus.rs_data;
        rt_mag    = rt_neg ? -bus.rt_data : bus.rt_data;

        // Shift-add: conditionally add, then shift {p,b} right one place.
        mul_sum   = {1'b0, p_q} + (b_q[0] ? {1'b0, a_q} : 33'd0);
        // Restoring divide: shift the next dividend bit into the remainder.
        div_shift = {p_q, b_q[31]};
        div_diff  = div_shift - {1'b0, a_q};
        div_ge    = (div_shift >= {1'b0, a_q});

        prod_fixed = neg_q ? -{p_q, b_q} : {p_q, b_q};
`ifdef HILO_FAST_MULT_EN
        fast_prod  = {32'd0, rs_mag} * {32'd0, rt_mag};
        if (rs_neg != rt_neg) begin
            fast_prod = -fast_prod;
        end
`endif

        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rs_neg_d = rs_neg_q;
        start    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    unique case (bus.funct)
                        F_MTHI: hi_d = bus.rs_data;
                        F_MTLO: lo_d = bus.rs_data;
`ifdef HILO_FAST_MULT_EN
                        F_MULT, F_MULTU: {hi_d, lo_d} = fast_prod;
`else
                        F_MULT, F_MULTU: start = 1'b1;
`endif
                        F_DIV, F_DIVU: start = 1'b1;
                        default: ;  // unrecognised funct: no-op
                    endcase
                end
                if (start) begin
                    a_d      = rt_mag;
                    b_d      = rs_mag;
                    p_d      = 32'd0;
                    is_div_d = (bus.funct == F_DIV) || (bus.funct == F_DIVU);
                    neg_d    = rs_neg ^ rt_neg;
                    rs_neg_d = rs_neg;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (is_div_q) begin
                    p_d = div_ge ? div_diff[31:0] : div_shift[31:0];
                    b_d = {b_q[30:0], div_ge};
                end else begin
                    p_d = mul_sum[32:1];
                    b_d = {mul_sum[0], b_q[31:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    // With a zero divisor every step "succeeds", so p ends up
                    // holding the dividend magnitude and re-signing it restores
                    // rs_data as latched.
                    hi_d = rs_neg_q ? -p_q : p_q;
                    lo_d = (a_q == 32'd0) ? 32'hFFFF_FFFF : (neg_q ? -b_q : b_q);
                end else begin
                    {hi_d, lo_d} = prod_fixed;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the datapath registers are cleared too even though the
            // next issue reloads them; it keeps the unit fully deterministic.
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            p_q      <= 32'd0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rs_neg_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rs_neg_q <= rs_neg_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    // Only instructions that touch HI/LO are held back while busy.
    assign bus.stall = busy_q && (bus.hilo_read || strobe);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_unit
//
// Directed and random checks of hilo_muldiv_unit against an arithmetic
// reference model (64-bit integer multiply, truncating divide/modulo).
// Follows HILO_FAST_MULT_EN when the build defines it.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hilo_muldiv_unit_if bus ();

    hilo_muldiv_unit #(.ITER_CYCLES(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] rs,
                                              input logic [31:0] rt, input logic [31:0] hi_in,
                                              input logic [31:0] lo_in);
        longint a;
        longint b;
        longint q;
        longint r;
        case (f)
            6'h11: return {rs, lo_in};
            6'h13: return {hi_in, rs};
            6'h18: begin
                a = longint'($signed(rs));
                b = longint'($signed(rt));
                return 64'(a * b);
            end
            6'h19: begin
                a = longint'({32'd0, rs});
                b = longint'({32'd0, rt});
                return 64'(a * b);
            end
            6'h1a, 6'h1b: begin
                if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
                if (f == 6'h1a) begin
                    a = longint'($signed(rs));
                    b = longint'($signed(rt));
                end else begin
                    a = longint'({32'd0, rs});
                    b = longint'({32'd0, rt});
                end
                q = a / b;
                r = a % b;
                return {r[31:0], q[31:0]};
            end
            default: return {hi_in, lo_in};
        endcase
    endfunction

    function automatic bit is_iterative(input logic [5:0] f);
`ifdef HILO_FAST_MULT_EN
        return (f == 6'h1a) || (f == 6'h1b);
`else
        return (f >= 6'h18) && (f <= 6'h1b);
`endif
    endfunction

    // Inputs for the op are already on the bus; takes the issue edge,
    // then checks latency, busy length, HI/LO hold and the final result.
    task automatic finish_op(input string tag, input bit iter,
                             input logic [31:0] new_hi, input logic [31:0] new_lo);
        int cycles;
        @(posedge clk);
        #1;
        bus.HI_write = 2'b00;
        bus.LO_write = 2'b00;
        bus.funct    = 6'h00;
        if (iter) begin
            cycles = 0;
            @(negedge clk);
            while (bus.busy === 1'b1 && cycles < 100) begin
                if (cycles == 0 || cycles == 32) begin
                    check({tag, " hold_hi"}, bus.hi, exp_hi);
                    check({tag, " hold_lo"}, bus.lo, exp_lo);
                end
                cycles++;
                @(negedge clk);
            end
            check({tag, " busy_cycles"}, 32'(cycles), 32'd33);
        end else begin
            @(negedge clk);
            check({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
        end
        exp_hi = new_hi;
        exp_lo = new_lo;
        check({tag, " hi"}, bus.hi, exp_hi);
        check({tag, " lo"}, bus.lo, exp_lo);
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [1:0] hw,
                          input logic [1:0] lw, input logic [31:0] rs, input logic [31:0] rt);
        logic [63:0] r;
        bit issued;
        @(negedge clk);
        bus.funct    = f;
        bus.HI_write = hw;
        bus.LO_write = lw;
        bus.rs_data  = rs;
        bus.rt_data  = rt;
        issued = (hw == 2'b11) || (lw == 2'b11);
        r = issued ? ref_model(f, rs, rt, exp_hi, exp_lo) : {exp_hi, exp_lo};
        finish_op(tag, issued && is_iterative(f), r[63:32], r[31:0]);
    endtask

    localparam logic [5:0] OPS [6] = '{6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b};

    initial begin
        int cycles;
        logic [5:0]  f;
        logic [31:0] rs;
        logic [31:0] rt;

        reset         = 1'b1;
        bus.funct     = 6'h00;
        bus.HI_write  = 2'b00;
        bus.LO_write  = 2'b00;
        bus.hilo_read = 1'b0;
        bus.rs_data   = 32'd0;
        bus.rt_data   = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset stall", {31'd0, bus.stall}, 32'd0);

        // Directed cases.
        run_op("mthi", 6'h11, 2'b11, 2'b00, 32'h1234_5678, 32'd0);
        run_op("mtlo", 6'h13, 2'b00, 2'b11, 32'hCAFE_F00D, 32'd0);
        run_op("mthi_strobe01", 6'h11, 2'b01, 2'b10, 32'hDEAD_BEEF, 32'd0);
        run_op("nop_funct", 6'h20, 2'b11, 2'b11, 32'h0BAD_0BAD, 32'd1);
        run_op("mult_neg", 6'h18, 2'b11, 2'b11, 32'hFFFF_FFFE, 32'd3);
        run_op("multu_max", 6'h19, 2'b11, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_minint", 6'h18, 2'b11, 2'b11, 32'h8000_0000, 32'h8000_0000);
        run_op("div_neg", 6'h1a, 2'b11, 2'b11, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_zero", 6'h1b, 2'b11, 2'b11, 32'd7, 32'd0);
        run_op("div_zero_neg", 6'h1a, 2'b11, 2'b11, 32'hFFFF_FFF0, 32'd0);
        run_op("div_minint", 6'h1a, 2'b11, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);

        // Stall behaviour during a DIV, with a MULT held under stall.
        @(negedge clk);
        bus.funct    = 6'h1a;
        bus.HI_write = 2'b11;
        bus.LO_write = 2'b11;
        bus.rs_data  = 32'hFFFF_FFF9;
        bus.rt_data  = 32'd2;
        @(posedge clk);
        #1;
        bus.HI_write = 2'b00;
        bus.LO_write = 2'b00;
        bus.funct    = 6'h00;
        @(negedge clk);
        bus.hilo_read = 1'b1;
        #1 check("stall mfhi", {31'd0, bus.stall}, 32'd1);
        bus.hilo_read = 1'b0;
        #1 check("stall unrelated", {31'd0, bus.stall}, 32'd0);
        bus.funct    = 6'h18;
        bus.HI_write = 2'b11;
        bus.LO_write = 2'b11;
        bus.rs_data  = 32'hFFFF_FFFE;
        bus.rt_data  = 32'd3;
        #1 check("stall strobe", {31'd0, bus.stall}, 32'd1);
        cycles = 1;
        @(negedge clk);
        while (bus.busy === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        check("stall div busy_cycles", 32'(cycles), 32'd33);
        check("stall released", {31'd0, bus.stall}, 32'd0);
        check("stall div hi", bus.hi, 32'hFFFF_FFFF);
        check("stall div lo", bus.lo, 32'hFFFF_FFFD);
        exp_hi = 32'hFFFF_FFFF;
        exp_lo = 32'hFFFF_FFFD;
        finish_op("held_mult", is_iterative(6'h18), 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // Reset in cycle 10 of a DIV.
        @(negedge clk);
        bus.funct    = 6'h1b;
        bus.HI_write = 2'b11;
        bus.LO_write = 2'b11;
        bus.rs_data  = 32'd1000;
        bus.rt_data  = 32'd7;
        @(posedge clk);
        #1;
        bus.HI_write = 2'b00;
        bus.LO_write = 2'b00;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort hi", bus.hi, 32'd0);
        check("abort lo", bus.lo, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        run_op("mtlo_after_reset", 6'h13, 2'b00, 2'b11, 32'd5, 32'd0);

        // Random operations.
        for (int i = 0; i < 16; i++) begin
            f  = OPS[$urandom_range(0, 5)];
            rs = $urandom;
            rt = $urandom;
            case ($urandom_range(0, 5))
                0: rt = 32'd0;
                1: rs = 32'h8000_0000;
                2: rt = 32'($urandom_range(1, 20));
                3: rt = -32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op($sformatf("rand%0d_f%02h", i, f), f, 2'b11, 2'b11, rs, rt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Multi-cycle multiply/divide engine holding the architectural HI and LO registers. Sits directly downstream of the instruction decoder. Consumes the decoded `HI_write`/`LO_write` strobes, the R-type `funct` field and the register-file operands. Drives `hi`/`lo` to the MFHI/MFLO writeback mux and raises `stall` to freeze fetch/decode while a result is pending.

## Interface
Parameters:
- `ITER_CYCLES`, 32: iterative steps per MULT/DIV; fixed at 32 for a 32-bit datapath.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `funct`  in  6: R-type function field of the instruction in decode.
- `HI_write`  in  2: decoder strobe; only `2'b11` counts as a write.
- `LO_write`  in  2: decoder strobe; only `2'b11` counts as a write.
- `hilo_read`  in  1: decode instruction is MFHI/MFLO (writeback select 3 or 4).
- `rs_data`  in  32: operand A / MTHI-MTLO source.
- `rt_data`  in  32: operand B.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.
- `busy`  out  1: engine not IDLE.
- `stall`  out  1: pipeline freeze request.

## Operation
- Issue condition: `issue` = (`HI_write`==2'b11 | `LO_write`==2'b11) & ~`busy`. Strobe values 01/10 are ignored.
- MTHI (0x11): `hi` <= `rs_data` on the issue edge. `lo` unchanged. No busy.
- MTLO (0x13): `lo` <= `rs_data` on the issue edge. No busy.
- MULT 0x18, MULTU 0x19, DIV 0x1a, DIVU 0x1b:
  - On the issue edge, latch operand magnitudes, sign flags and op type.
  - Clear the step counter and move IDLE -> RUN.
- FSM states:
  - IDLE: accepts issue.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Counter counts 0..31; after step 31 -> FIX.
  - FIX: apply sign fixup, write `hi`/`lo`, -> IDLE.
- Signed arithmetic:
  - Operate on unsigned magnitudes; 0x80000000 has magnitude 2^31.
  - Product is negated (64-bit two's complement) when operand signs differ.
  - Quotient is negated when signs differ; remainder takes the dividend's sign.
- Results: multiply writes `hi`=product[63:32], `lo`=product[31:0]. Divide writes `lo`=quotient, `hi`=remainder.
- Divide by zero (DIV or DIVU): skip fixup; `hi`=`rs_data` as latched, `lo`=0xFFFFFFFF.
- `busy` = (state != IDLE).
- `stall` = `busy` & (`hilo_read` | `HI_write`==2'b11 | `LO_write`==2'b11). Unrelated instructions are never stalled.
- Strobes presented while busy are not accepted. Decode holds the instruction under `stall` and it issues in the first IDLE cycle.
- Any other funct with a 2'b11 strobe is treated as a no-op: no state change.

## Timing
- Reset values: `hi`=0, `lo`=0, state IDLE, counter 0, `busy`=0, `stall`=0.
- MTHI/MTLO: latency 1; value visible in the cycle after the issue edge.
- MULT/DIV family, issue edge at cycle N:
  - `busy` is high during cycles N+1 .. N+33.
  - `hi`/`lo` update at edge N+33.
  - `busy` is low from cycle N+34; a stalled MFHI/MFLO reads the new value in that cycle.
- Back-to-back ops: a second op issues no earlier than edge N+34.
- Reset mid-operation: on the reset edge, abort to IDLE and clear `hi`/`lo` to 0. The partial result is discarded.
- `hi`/`lo` hold their values throughout RUN. They change only on an MT edge, on the FIX edge, or on reset.

## Configuration
- `HILO_FAST_MULT_EN` defined:
  - MULT/MULTU use a single-cycle combinational 32x32 multiplier.
  - `hi`/`lo` are written on the issue edge and `busy` never rises for multiplies.
  - DIV/DIVU remain iterative, 33-cycle.
- `HILO_FAST_MULT_EN` undefined: all four ops use the iterative 33-cycle path above.

## Test plan
- MTHI with `rs_data`=0x12345678 -> `hi`=0x12345678 after 1 edge; `lo` unchanged; `busy` stays 0.
- MULT with rs=0xFFFFFFFE (-2), rt=3 -> `busy` high exactly 33 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. With `HILO_FAST_MULT_EN`: same values after 1 edge, `busy`=0.
- MULTU with 0xFFFFFFFF x 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 7/0 -> `hi`=7, `lo`=0xFFFFFFFF.
- During a DIV:
  - `hilo_read`=1 -> `stall`=1 until `busy` falls.
  - `hilo_read`=0 with no strobes -> `stall`=0.
  - A MULT strobe held under stall issues on the first IDLE edge.
- Reset asserted in cycle 10 of a DIV -> next edge `busy`=0, `hi`=`lo`=0. A subsequent MTLO 0x5 gives `lo`=5.
